// File: rtl/mlu_pkg.sv
// Shared types and helpers for the MLU accumulate/reduce path.
//   - Default lane, accumulator and lane-count sizes.
//   - lane_t / acc_t: signed lane and accumulator types.
//   - acc_state_e: the reduce controller states.
//   - sat_shift(): arithmetic rescale of the accumulator, then saturation
//     to lane width. It returns the result value and an overflow flag.
package mlu_pkg;

  localparam int MLU_LANES     = 16;
  localparam int MLU_WIDTH     = 32;
  localparam int MLU_ACC_WIDTH = 48;

  typedef logic signed [MLU_WIDTH-1:0]     lane_t;
  typedef logic signed [MLU_ACC_WIDTH-1:0] acc_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} acc_state_e;

  typedef struct packed {
    lane_t data;
    logic  overflow;
  } sat_res_t;

  function automatic sat_res_t sat_shift(input acc_t acc, input logic [7:0] shift);
    acc_t                             r;
    logic [MLU_ACC_WIDTH-MLU_WIDTH:0] hi;
    sat_res_t                         res;
    // A shift at or beyond the accumulator width leaves only sign fill.
    if (shift >= 8'(MLU_ACC_WIDTH)) begin
      r = acc[MLU_ACC_WIDTH-1] ? '1 : '0;
    end else begin
      r = acc >>> shift;
    end
    // The value fits in lane width when every bit above the lane sign bit
    // matches that sign bit.
    hi = r[MLU_ACC_WIDTH-1:MLU_WIDTH-1];
    if ((&hi) || !(|hi)) begin
      res.data     = r[MLU_WIDTH-1:0];
      res.overflow = 1'b0;
    end else if (r[MLU_ACC_WIDTH-1]) begin
      res.data     = {1'b1, {(MLU_WIDTH-1){1'b0}}};
      res.overflow = 1'b1;
    end else begin
      res.data     = {1'b0, {(MLU_WIDTH-1){1'b1}}};
      res.overflow = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mlu_add_tree16.sv
// Two-stage registered 4:1/4:1 adder tree for 16 signed lanes.
// The tree advances on every clock, and a valid bit travels alongside the data.
//   clk, rst_n : clock and synchronous active-low reset (clears the valid bits)
//   in_valid   : the current in_data is a real beat
//   in_data    : 16 signed lanes, WIDTH bits each
//   sum_valid  : sum holds the reduced value of a real beat
//   sum        : sign-extended total of the 16 lanes, ACC_WIDTH bits
//   pipe_busy  : some stage of the tree still holds a real beat
module mlu_add_tree16
  import mlu_pkg::*;
#(
  parameter int WIDTH     = MLU_WIDTH,
  parameter int ACC_WIDTH = MLU_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     in_data [15:0],
  output logic                        sum_valid,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        pipe_busy
);

  logic signed [ACC_WIDTH-1:0] ext  [15:0];
  logic signed [ACC_WIDTH-1:0] part [3:0];
  logic                        part_valid;

  for (genvar i = 0; i < 16; i++) begin : g_ext
    assign ext[i] = {{(ACC_WIDTH-WIDTH){in_data[i][WIDTH-1]}}, in_data[i]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      part_valid <= 1'b0;
      sum_valid  <= 1'b0;
      part       <= '{default: '0};
      sum        <= '0;
    end else begin
      part_valid <= in_valid;
      part[0]    <= ext[0]  + ext[1]  + ext[2]  + ext[3];
      part[1]    <= ext[4]  + ext[5]  + ext[6]  + ext[7];
      part[2]    <= ext[8]  + ext[9]  + ext[10] + ext[11];
      part[3]    <= ext[12] + ext[13] + ext[14] + ext[15];
      sum_valid  <= part_valid;
      sum        <= part[0] + part[1] + part[2] + part[3];
    end
  end

  assign pipe_busy = part_valid | sum_valid;

endmodule

// File: rtl/mlu_acc_reduce.sv
// Reduce-and-accumulate consumer for the MLU's 16-lane product bus.
// Each accepted vector is summed to a scalar by mlu_add_tree16. The block
// accumulates vec_len of these scalars, rescales the total with an arithmetic
// right shift, saturates it to WIDTH bits, and offers it on a valid/ready port.
//   clk, rst_n          : clock and synchronous active-low reset
//   start               : one-cycle job start pulse, honoured only in IDLE
//   vec_len             : number of vectors in the job (0 gives an immediate zero result)
//   shift_right         : output rescale amount
//   in_valid / in_ready : product vector handshake
//   in_data             : LANES signed products
//   out_valid/out_ready : result handshake
//   out_data, overflow  : saturated result and saturation flag
//   busy                : high whenever the block is not in IDLE
module mlu_acc_reduce
  import mlu_pkg::*;
#(
  parameter int WIDTH     = MLU_WIDTH,
  parameter int LANES     = MLU_LANES,
  parameter int ACC_WIDTH = MLU_ACC_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    vec_len,
  input  logic [7:0]              shift_right,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data [LANES-1:0],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    overflow,
  output logic                    busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  acc_state_e                  state;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [CNT_WIDTH-1:0]        len;
  logic [7:0]                  shamt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        acc_upd;
  logic                        accept;
  logic                        tree_valid;
  logic signed [ACC_WIDTH-1:0] tree_sum;
  logic                        tree_busy;
  sat_res_t                    res;

  assign accept = in_valid && in_ready;

  mlu_add_tree16 #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept),
    .in_data  (in_data),
    .sum_valid(tree_valid),
    .sum      (tree_sum),
    .pipe_busy(tree_busy)
  );

  always_comb begin
    res = sat_shift(acc, shamt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      len       <= '0;
      shamt     <= '0;
      acc       <= '0;
      acc_upd   <= 1'b0;
    end else begin
      // acc_upd marks the cycle after an accumulate. DRAIN waits for it to
      // clear, so the result is taken only after the last add has settled.
      acc_upd <= tree_valid;
      if (tree_valid) begin
        acc <= acc + tree_sum;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            len   <= vec_len;
            shamt <= shift_right;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            if (vec_len != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
            end else begin
              state     <= OUT;
              out_valid <= 1'b1;
              out_data  <= '0;
              overflow  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + CNT_ONE;
            if (cnt + CNT_ONE == len) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!tree_busy && !acc_upd) begin
            out_data  <= res.data;
            overflow  <= res.overflow;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlu_acc_reduce.sv
module tb_mlu_acc_reduce;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [15:0]        vec_len;
  logic [7:0]         shift_right;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data [15:0];
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic               overflow;
  logic               busy;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  always #5 clk = ~clk;

  mlu_acc_reduce #(
    .WIDTH    (32),
    .LANES    (16),
    .ACC_WIDTH(48),
    .CNT_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vec_len    (vec_len),
    .shift_right(shift_right),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .overflow   (overflow),
    .busy       (busy)
  );

  typedef struct {
    int unsigned        len;
    int unsigned        sh;
    logic signed [31:0] base;
    logic signed [31:0] step;
    logic [31:0]        exp_data;
    logic               exp_ovf;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Runs one job. Every beat carries lane i = base + step*i. The job can
  // insert random input gaps, hold out_ready low for `hold` cycles, or pulse
  // start mid-run.
  task automatic run_job(input int unsigned len, input logic [7:0] sh,
                         input logic signed [31:0] base, input logic signed [31:0] step,
                         input bit gaps, input int unsigned hold, input bit mid_start,
                         input logic [31:0] exp_data, input logic exp_ovf, input int idx);
    int unsigned sent, guard, ready_cyc, lat;
    logic [31:0] held;
    bit          stable;
    for (int i = 0; i < 16; i++) in_data[i] = base + step * i;
    @(negedge clk);
    vec_len = len[15:0];
    shift_right = sh;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      check("zero_len_valid", idx, {31'b0, out_valid}, 32'd1);
    end else begin
      sent = 0; guard = 0; ready_cyc = 0;
      while (sent < len && guard < 500) begin
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        start = mid_start && (sent == 2);
        if (start) vec_len = 16'd1;
        if (in_ready) ready_cyc++;
        if (in_valid && in_ready) sent++;
        @(negedge clk);
        guard++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      check("beats_accepted", idx, sent, len);
      check("ready_drop", idx, {31'b0, in_ready}, 32'd0);
      if (!gaps) check("ready_cycles", idx, ready_cyc, len);
      lat = 0;
      while (!out_valid && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      check("latency", idx, lat, 32'd4);
    end
    check("busy_out", idx, {31'b0, busy}, 32'd1);
    if (hold != 0) begin
      held = out_data;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (out_data !== held || out_valid !== 1'b1) stable = 1'b0;
      end
      check("hold_stable", idx, {31'b0, stable}, 32'd1);
    end
    check("out_data", idx, out_data, exp_data);
    check("overflow", idx, {31'b0, overflow}, {31'b0, exp_ovf});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_hs", idx, {31'b0, out_valid}, 32'd0);
    check("busy_after_hs", idx, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    //            len sh  base              step   exp_data       ovf
    tbl[0]  = '{1,  0,  32'sd1,           32'sd0, 32'h0000_0010, 1'b0};
    tbl[1]  = '{4,  0, -32'sd8,           32'sd1, 32'hFFFF_FFE0, 1'b0};
    tbl[2]  = '{1,  16, 32'shFFFF0000,    32'sd0, 32'hFFFF_FFF0, 1'b0};
    tbl[3]  = '{2,  0,  32'sh40000000,    32'sd0, 32'h7FFF_FFFF, 1'b1};
    tbl[4]  = '{2,  0,  32'shC0000000,    32'sd0, 32'h8000_0000, 1'b1};
    tbl[5]  = '{0,  3,  32'sd9,           32'sd0, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1,  60, -32'sd1,          32'sd0, 32'hFFFF_FFFF, 1'b0};
    tbl[7]  = '{1,  48, 32'sd5,           32'sd0, 32'h0000_0000, 1'b0};
    tbl[8]  = '{3,  2,  32'sd7,           32'sd0, 32'h0000_0054, 1'b0};
    tbl[9]  = '{1,  1,  -32'sd3,          32'sd0, 32'hFFFF_FFE8, 1'b0};
    tbl[10] = '{1,  4,  32'sh7FFFFFFF,    32'sd0, 32'h7FFF_FFFF, 1'b0};
    tbl[11] = '{1,  4,  32'sh80000000,    32'sd0, 32'h8000_0000, 1'b0};
    tbl[12] = '{1,  0,  32'sh08000000,    32'sd0, 32'h7FFF_FFFF, 1'b1};
    tbl[13] = '{1,  0,  32'sd0,           32'sd1, 32'h0000_0078, 1'b0};

    rst_n = 1'b0; start = 1'b0; vec_len = '0; shift_right = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) in_data[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 0, {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", 0, {31'b0, out_valid}, 32'd0);
    check("rst_out_data", 0, out_data, 32'd0);
    check("rst_overflow", 0, {31'b0, overflow}, 32'd0);
    check("rst_busy", 0, {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 14; k++) begin
      run_job(tbl[k].len, 8'(tbl[k].sh), tbl[k].base, tbl[k].step, 1'b0, 0, 1'b0,
              tbl[k].exp_data, tbl[k].exp_ovf, k);
    end

    // Random input gaps and a 10-cycle output stall: 5 x (sum of 3+i) = 5 x 168.
    run_job(5, 8'd0, 32'sd3, 32'sd1, 1'b1, 10, 1'b0, 32'd840, 1'b0, 100);

    // start pulsed mid-run must not disturb the 4-vector job: 4 x 16 x 2.
    run_job(4, 8'd0, 32'sd2, 32'sd0, 1'b0, 0, 1'b1, 32'd128, 1'b0, 101);

    // Reset after two of four beats, then a fresh 1-vector job of lanes=2.
    for (int i = 0; i < 16; i++) in_data[i] = 32'sd100;
    @(negedge clk);
    vec_len = 16'd4; shift_right = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 102, {31'b0, busy}, 32'd0);
    check("midrst_in_ready", 102, {31'b0, in_ready}, 32'd0);
    check("midrst_out_valid", 102, {31'b0, out_valid}, 32'd0);
    run_job(1, 8'd0, 32'sd2, 32'sd0, 1'b0, 0, 1'b0, 32'd32, 1'b0, 103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
